qam_frame_ctrl: RTL and testbench

QAM_FRAME_CTRL -- requirements
Module: qam_frame_ctrl

---
 rtl/qam_frame_ctrl.sv | 176 +++++++++++++++++
 tb/tb_qam_frame_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/qam_frame_ctrl.sv
// Frame controller for the QAM modulator: wraps each payload burst with an
// alternating preamble, a silent guard interval and a one-cycle done pulse.
module qam_frame_ctrl #(
    parameter int PRE_LEN   = 8,
    parameter int GUARD_LEN = 4,
    parameter int LEN_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             sym_valid,
    input  logic [1:0]       SigI_in,
    input  logic [1:0]       SigQ_in,
    output logic             gen_en,
    output logic [1:0]       SigI,
    output logic [1:0]       SigQ,
    output logic             sym_out_valid,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    // Handshake: the upstream stage may present a symbol only while gen_en is
    // high; sym_valid=1 in that window transfers SigI_in/SigQ_in, there is no
    // back-pressure. sym_out_valid=1 marks a symbol on SigI/SigQ that cycle.

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        PAYLOAD  = 3'd2,
        GUARD    = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int PH_MAX = (PRE_LEN > GUARD_LEN) ? PRE_LEN : GUARD_LEN;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] PRE_LAST   = PH_W'(PRE_LEN - 1);
    localparam logic [PH_W-1:0] GUARD_LAST = PH_W'(GUARD_LEN - 1);

    state_t           r_state;
    logic [PH_W-1:0]  r_phase;
    logic [LEN_W-1:0] r_sym_cnt;
    logic [LEN_W-1:0] r_len;

    state_t           w_next_state;
    logic [PH_W-1:0]  w_next_phase;
    logic [LEN_W-1:0] w_next_sym_cnt;
    logic [LEN_W-1:0] w_next_len;
    logic [1:0]       w_next_sig_i;
    logic [1:0]       w_next_sig_q;
    logic             w_next_valid;

    assign dbg_state = r_state;

    always_comb begin
        w_next_state   = r_state;
        w_next_phase   = r_phase;
        w_next_sym_cnt = r_sym_cnt;
        w_next_len     = r_len;
        w_next_sig_i   = SigI;
        w_next_sig_q   = SigQ;
        w_next_valid   = 1'b0;

        case (r_state)
            IDLE: begin
                w_next_sig_i = 2'b00;
                w_next_sig_q = 2'b00;
                if (start && !abort) begin
                    w_next_state   = PREAMBLE;
                    w_next_len     = frame_len;
                    w_next_phase   = '0;
                    w_next_sym_cnt = '0;
                    w_next_sig_i   = 2'b11;
                    w_next_sig_q   = 2'b00;
                    w_next_valid   = 1'b1;
                end
            end

            PREAMBLE: begin
                if (r_phase == PRE_LAST) begin
                    w_next_phase = '0;
                    if (r_len != '0) begin
                        w_next_state = PAYLOAD;
                    end else begin
                        w_next_state = GUARD;
                        w_next_sig_i = 2'b00;
                        w_next_sig_q = 2'b00;
                    end
                end else begin
                    // Symbol index r_phase+1: odd indices carry {00,11}.
                    w_next_phase = r_phase + PH_W'(1);
                    w_next_sig_i = r_phase[0] ? 2'b11 : 2'b00;
                    w_next_sig_q = r_phase[0] ? 2'b00 : 2'b11;
                    w_next_valid = 1'b1;
                end
            end

            PAYLOAD: begin
                // The counter stops at the latched length, so late sym_valid is dropped.
                if (r_sym_cnt == r_len) begin
                    w_next_state = GUARD;
                    w_next_phase = '0;
                    w_next_sig_i = 2'b00;
                    w_next_sig_q = 2'b00;
                end else if (sym_valid) begin
                    w_next_sig_i   = SigI_in;
                    w_next_sig_q   = SigQ_in;
                    w_next_valid   = 1'b1;
                    w_next_sym_cnt = r_sym_cnt + LEN_W'(1);
                end
            end

            GUARD: begin
                w_next_sig_i = 2'b00;
                w_next_sig_q = 2'b00;
                if (r_phase == GUARD_LAST) begin
                    w_next_state = DONE;
                    w_next_phase = '0;
                end else begin
                    w_next_phase = r_phase + PH_W'(1);
                end
            end

            DONE: begin
                w_next_sig_i = 2'b00;
                w_next_sig_q = 2'b00;
                w_next_state = IDLE;
            end

            default: begin
                w_next_state = IDLE;
                w_next_sig_i = 2'b00;
                w_next_sig_q = 2'b00;
            end
        endcase

        // Abort overrides every transition above, including frame completion.
        if (abort && (r_state != IDLE)) begin
            w_next_state   = IDLE;
            w_next_phase   = '0;
            w_next_sym_cnt = '0;
            w_next_sig_i   = 2'b00;
            w_next_sig_q   = 2'b00;
            w_next_valid   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_phase       <= '0;
            r_sym_cnt     <= '0;
            r_len         <= '0;
            gen_en        <= 1'b0;
            SigI          <= 2'b00;
            SigQ          <= 2'b00;
            sym_out_valid <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_phase       <= w_next_phase;
            r_sym_cnt     <= w_next_sym_cnt;
            r_len         <= w_next_len;
            gen_en        <= (w_next_state == PAYLOAD);
            SigI          <= w_next_sig_i;
            SigQ          <= w_next_sig_q;
            sym_out_valid <= w_next_valid;
            busy          <= (w_next_state != IDLE);
            done          <= (w_next_state == DONE);
        end
    end

endmodule

// File: tb/tb_qam_frame_ctrl.sv
// Directed bench for qam_frame_ctrl: per-cycle expected output words are queued
// from the frame format and compared on the falling clock edge.
module tb_qam_frame_ctrl;

    localparam int PRE_LEN   = 8;
    localparam int GUARD_LEN = 4;
    localparam int LEN_W     = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [LEN_W-1:0] frame_len;
    logic             sym_valid;
    logic [1:0]       SigI_in;
    logic [1:0]       SigQ_in;
    logic             gen_en;
    logic [1:0]       SigI;
    logic [1:0]       SigQ;
    logic             sym_out_valid;
    logic             busy;
    logic             done;
    logic [2:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    qam_frame_ctrl #(
        .PRE_LEN(PRE_LEN), .GUARD_LEN(GUARD_LEN), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst_n), .start(start), .abort(abort),
        .frame_len(frame_len), .sym_valid(sym_valid),
        .SigI_in(SigI_in), .SigQ_in(SigQ_in), .gen_en(gen_en),
        .SigI(SigI), .SigQ(SigQ), .sym_out_valid(sym_out_valid),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Observed word: {busy, gen_en, done, sym_out_valid, SigI, SigQ}
    wire [7:0] obs = {busy, gen_en, done, sym_out_valid, SigI, SigQ};
    localparam logic [7:0] IDLE_W  = 8'h00;
    localparam logic [7:0] GUARD_W = 8'h80;
    localparam logic [7:0] DONE_W  = 8'hA0;

    function automatic logic [7:0] mk(input logic b, input logic g, input logic d,
                                      input logic v, input logic [1:0] i, input logic [1:0] q);
        return {b, g, d, v, i, q};
    endfunction

    function automatic logic [7:0] pre_exp(input int k);
        if (k % 2 == 0) return mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00);
        else            return mk(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b11);
    endfunction

    task automatic tick(input string tag);
        logic [7:0] e;
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s no expected entry, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    // mode 0: sym_valid tied 1 with stepped data, 1: toggling, 2: random.
    task automatic frame(input int len, input int mode, input bit start_pay, input bit start_done);
        logic [1:0] li, lq, pi, pq;
        logic [1:0] bi[3];
        logic [1:0] bq[3];
        logic       pend, v, tog;
        int         cnt, pcyc;
        bi = '{2'b01, 2'b10, 2'b11};
        bq = '{2'b10, 2'b01, 2'b11};
        exp_q.push_back(IDLE_W);
        tick("idle_before_start");
        start = 1'b1; abort = 1'b0; sym_valid = 1'b0; frame_len = LEN_W'(len);
        for (int k = 0; k < PRE_LEN; k++) begin
            exp_q.push_back(pre_exp(k));
            tick("preamble");
            start = 1'b0;
        end
        // Last preamble index is odd, so the held value entering payload is 00/11.
        li = 2'b00; lq = 2'b11; pi = 2'b00; pq = 2'b00;
        if (len != 0) begin
            cnt = 0; pend = 1'b0; pcyc = 0; tog = 1'b1;
            while (pcyc < 4000) begin
                if (pend) begin li = pi; lq = pq; end
                exp_q.push_back(mk(1'b1, 1'b1, 1'b0, pend, li, lq));
                tick("payload");
                if (cnt == len) begin
                    sym_valid = 1'b1;
                    SigI_in = 2'($urandom_range(0, 3));
                    SigQ_in = 2'($urandom_range(0, 3));
                    break;
                end
                case (mode)
                    0:       v = 1'b1;
                    1:       begin v = tog; tog = ~tog; end
                    default: v = 1'($urandom_range(0, 1));
                endcase
                sym_valid = v;
                if (mode == 0 && cnt < 3) begin
                    SigI_in = bi[cnt]; SigQ_in = bq[cnt];
                end else begin
                    SigI_in = 2'($urandom_range(0, 3));
                    SigQ_in = 2'($urandom_range(0, 3));
                end
                start = (start_pay && pcyc == 1);
                pend = v;
                if (v) begin pi = SigI_in; pq = SigQ_in; cnt++; end
                pcyc++;
            end
            start = 1'b0;
        end
        for (int g = 0; g < GUARD_LEN; g++) begin
            exp_q.push_back(GUARD_W);
            tick("guard");
            sym_valid = 1'b0;
        end
        exp_q.push_back(DONE_W);
        tick("done_pulse");
        start = start_done;
        exp_q.push_back(IDLE_W);
        tick("idle_after_done");
        start = 1'b0;
        exp_q.push_back(IDLE_W);
        tick("no_restart");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; frame_len = '0;
        sym_valid = 1'b0; SigI_in = 2'b00; SigQ_in = 2'b00;
        repeat (2) @(negedge clk);
        checks++;
        assert (obs === IDLE_W && dbg_state === 3'd0) else begin
            errors++;
            $error("FAIL reset_state observed=%h/%0d expected=%h/0", obs, dbg_state, IDLE_W);
        end
        rst_n = 1'b1;

        // Basic frame, gapped input, zero length, maximum length.
        frame(3, 0, 1'b0, 1'b0);
        frame(4, 1, 1'b0, 1'b0);
        frame(0, 0, 1'b0, 1'b0);
        frame(255, 2, 1'b0, 1'b0);
        // Start pulses during payload and during done are ignored.
        frame(4, 0, 1'b1, 1'b1);

        // Start together with abort in idle stays idle.
        exp_q.push_back(IDLE_W);
        tick("idle_pre_both");
        start = 1'b1; abort = 1'b1;
        exp_q.push_back(IDLE_W);
        tick("start_abort_idle");
        start = 1'b0; abort = 1'b0;

        // Abort in the second payload cycle of a 10-symbol frame.
        exp_q.push_back(IDLE_W);
        tick("idle_pre_abort");
        start = 1'b1; frame_len = LEN_W'(10);
        for (int k = 0; k < PRE_LEN; k++) begin
            exp_q.push_back(pre_exp(k));
            tick("abort_preamble");
            start = 1'b0;
        end
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b11));
        tick("abort_payload1");
        sym_valid = 1'b1; SigI_in = 2'b10; SigQ_in = 2'b01;
        exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b01));
        tick("abort_payload2");
        abort = 1'b1; SigI_in = 2'b11; SigQ_in = 2'b11;
        exp_q.push_back(IDLE_W);
        tick("abort_cleared");
        abort = 1'b0; sym_valid = 1'b0;
        exp_q.push_back(IDLE_W);
        tick("abort_no_done");
        frame(2, 0, 1'b0, 1'b0);

        // Asynchronous reset between edges during the preamble.
        exp_q.push_back(IDLE_W);
        tick("idle_pre_reset");
        start = 1'b1; frame_len = LEN_W'(5);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(pre_exp(k));
            tick("reset_preamble");
            start = 1'b0;
        end
        #2;
        rst_n = 1'b0; start = 1'b1;
        #1;
        checks++;
        assert (obs === IDLE_W && dbg_state === 3'd0) else begin
            errors++;
            $error("FAIL async_reset observed=%h/%0d expected=%h/0", obs, dbg_state, IDLE_W);
        end
        exp_q.push_back(IDLE_W);
        tick("reset_hold1");
        exp_q.push_back(IDLE_W);
        tick("reset_hold2");
        rst_n = 1'b1; start = 1'b0;
        exp_q.push_back(IDLE_W);
        tick("after_reset_idle");
        frame(1, 1, 1'b0, 1'b0);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
